data_mem_lsu: RTL

- Parametrised, byte-addressed RV32I data memory with an integrated load/store formatter.
- Supports LB/LH/LW/LBU/LHU/SB/SH/SW through per-byte write lanes and load sign/zero extension.
- Uses a valid/ready request channel and a registered response with fault reporting.
- Sits between the core's execute/memory stage and data storage, and replaces the word-indexed, combinational-read data memory.

---
 rtl/data_mem_lsu_if.sv | 25 ++
 rtl/data_mem_lsu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu_if.sv
// Request/response channel between the core's memory stage and data_mem_lsu.
// Requests use a valid/ready handshake. The registered response is a one-cycle valid pulse.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressed RV32I data memory with load/store formatting (LB/LH/LW/LBU/LHU/SB/SH/SW).
// Each request takes two cycles. Faults suppress the write and produce rsp_err with zero data.
module data_mem_lsu #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    ADDR_W      = 32,
  parameter string INIT_FILE   = ""
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  logic [31:0]      mem_r [DEPTH_WORDS];
  state_t           state_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_err_r;
  logic             we_r;
  logic [2:0]       funct3_r;
  logic [1:0]       off_r;
  logic             err_r;
  logic [31:0]      rd_word_r;

  logic             accept_s;
  logic             illegal_s;
  logic             misaligned_s;
  logic             out_of_range_s;
  logic             fault_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic [3:0]       lanes_s;
  logic [31:0]      wdata_rep_s;
  logic [31:0]      shifted_s;
  logic [31:0]      load_data_s;

  assign idx_s    = bus.req_addr[IDX_W+1:2];
  assign off_s    = bus.req_addr[1:0];
  assign accept_s = (state_r == IDLE) && bus.req_valid;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  // Decode the incoming request: fault flags, store lane enables and replicated store data
  always_comb begin
    illegal_s      = 1'b0;
    misaligned_s   = 1'b0;
    lanes_s        = 4'b0000;
    wdata_rep_s    = bus.req_wdata;
    out_of_range_s = |bus.req_addr[ADDR_W-1:IDX_W+2];
    case (bus.req_funct3)
      3'd0: begin
        lanes_s     = 4'b0001 << off_s;
        wdata_rep_s = {4{bus.req_wdata[7:0]}};
      end
      3'd1: begin
        lanes_s      = 4'b0011 << off_s;
        wdata_rep_s  = {2{bus.req_wdata[15:0]}};
        misaligned_s = off_s[0];
      end
      3'd2: begin
        lanes_s      = 4'b1111;
        misaligned_s = (off_s != 2'd0);
      end
      3'd4: illegal_s = bus.req_we;
      3'd5: begin
        illegal_s    = bus.req_we;
        misaligned_s = off_s[0];
      end
      default: illegal_s = 1'b1;
    endcase
    fault_s = illegal_s | misaligned_s | out_of_range_s;
  end

  // Storage: lane-enabled writes on a clean store accept, synchronous word read on every accept
  always_ff @(posedge clk) begin
    if (accept_s) begin
      if (bus.req_we && !fault_s) begin
        for (int i = 0; i < 4; i++) begin
          if (lanes_s[i]) begin
            mem_r[idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
          end
        end
      end
      rd_word_r <= mem_r[idx_s];
    end
  end

  // Shift the addressed byte/halfword down and extend it according to the latched funct3
  always_comb begin
    shifted_s = rd_word_r >> {off_r, 3'b000};
    case (funct3_r)
      3'd0:    load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'd1:    load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'd2:    load_data_s = rd_word_r;
      3'd4:    load_data_s = {24'h000000, shifted_s[7:0]};
      3'd5:    load_data_s = {16'h0000, shifted_s[15:0]};
      default: load_data_s = 32'h0000_0000;
    endcase
    if (we_r || err_r) begin
      load_data_s = 32'h0000_0000;
    end else begin
      load_data_s = load_data_s;
    end
  end

  // Control FSM: accept in IDLE, respond with a one-cycle pulse on leaving ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (bus.req_valid) begin
            we_r        <= bus.req_we;
            funct3_r    <= bus.req_funct3;
            off_r       <= off_s;
            err_r       <= fault_s;
            state_r     <= ACCESS;
            req_ready_r <= 1'b0;
          end
        end
        ACCESS: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= load_data_s;
          rsp_err_r   <= err_r;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
